// File: rtl/qnr_div_scheduler.sv
// rtl/qnr_div_scheduler.sv - shares one fixed-latency pipelined divider between two requesters
// Results are tagged down a matching shift pipe and land in a credited result FIFO.
module qnr_div_scheduler #(
   parameter int DW     = 16,
   parameter int LAT    = 16,
   parameter int FDEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_num,
   input  logic [DW-1:0] req0_den,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_num,
   input  logic [DW-1:0] req1_den,
   output logic          req1_ready,
   output logic [DW-1:0] div_num,
   output logic [DW-1:0] div_den,
   input  logic [DW-1:0] div_q,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_q,
   output logic          res_id,
   output logic          busy
);
   localparam int CW = $clog2(LAT + FDEPTH + 1);
   localparam int OW = $clog2(FDEPTH + 1);
   localparam int PW = $clog2(FDEPTH);

   logic              rr;
   logic [LAT-1:0]    tag_v;
   logic [LAT-1:0]    tag_id;
   logic [CW-1:0]     inflight;
   logic [OW-1:0]     occ;
   logic [PW-1:0]     wptr;
   logic [PW-1:0]     rptr;
   logic [DW-1:0]     mem_q [FDEPTH];
   logic [FDEPTH-1:0] mem_id;
   logic [CW:0]       used;
   logic              allow;
   logic              grant0;
   logic              grant1;
   logic              grant;
   logic              push;
   logic              pop;

   // A pop in the same cycle is deliberately not credited back to the issue check.
   always_comb begin
      used   = (CW+1)'(occ) + (CW+1)'(inflight);
      allow  = !rst && (used < (CW+1)'(FDEPTH));
      grant0 = allow && req0_valid && (!req1_valid || !rr);
      grant1 = allow && req1_valid && (!req0_valid || rr);
      grant  = grant0 || grant1;
      div_num = '0;
      div_den = '0;
      if (grant0) begin
         div_num = req0_num;
         div_den = req0_den;
      end else if (grant1) begin
         div_num = req1_num;
         div_den = req1_den;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign push       = tag_v[LAT-1];
   assign res_valid  = (occ != '0);
   assign pop        = res_valid && res_ready;
   assign res_q      = mem_q[rptr];
   assign res_id     = mem_id[rptr];
   assign busy       = (inflight != '0) || (occ != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr       <= 1'b0;
         tag_v    <= '0;
         tag_id   <= '0;
         inflight <= '0;
         occ      <= '0;
         wptr     <= '0;
         rptr     <= '0;
      end else begin
         if (grant) rr <= grant0;
         tag_v[0]  <= grant;
         tag_id[0] <= grant1;
         for (int i = 1; i < LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
         if (grant && !push)      inflight <= inflight + 1'b1;
         else if (!grant && push) inflight <= inflight - 1'b1;
         if (push && !pop)        occ <= occ + 1'b1;
         else if (pop && !push)   occ <= occ - 1'b1;
         if (push) wptr <= (wptr == PW'(FDEPTH - 1)) ? '0 : wptr + 1'b1;
         if (pop)  rptr <= (rptr == PW'(FDEPTH - 1)) ? '0 : rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr]  <= div_q;
         mem_id[wptr] <= tag_id[LAT-1];
      end
   end

   no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && occ == OW'(FDEPTH)));
endmodule

// File: tb/tb_qnr_div_scheduler.sv
// tb/tb_qnr_div_scheduler.sv - randomized self-checking bench for qnr_div_scheduler
// Reference model: issue-order queue with due cycles and outstanding-op credit.
module tb_qnr_div_scheduler;
   localparam int DW     = 16;
   localparam int LAT    = 16;
   localparam int FDEPTH = 4;
   localparam int VW     = 5 + 3 * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
   logic [DW-1:0] req0_num = '0, req0_den = '0, req1_num = '0, req1_den = '0;
   logic          req0_ready, req1_ready, res_valid, res_id, busy;
   logic [DW-1:0] div_num, div_den, div_q, res_q;

   qnr_div_scheduler #(.DW(DW), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_num(req0_num), .req0_den(req0_den), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_num(req1_num), .req1_den(req1_den), .req1_ready(req1_ready),
      .div_num(div_num), .div_den(div_den), .div_q(div_q),
      .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_id(res_id), .busy(busy)
   );

   always #5 clk = ~clk;

   // External pipelined divider: quotient appears LAT cycles after operands.
   logic [DW-1:0] dpipe [LAT];
   always @(posedge clk) begin
      dpipe[0] <= (div_den == '0) ? {DW{1'b1}} : div_num / div_den;
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
   end
   assign div_q = dpipe[LAT-1];

   typedef struct {
      logic [DW-1:0] q;
      logic          id;
      int            due;
   } rec_t;

   rec_t          mq[$];
   int            cyc = 0;
   int            passed = 0;
   int            total = 0;
   bit            m_rr = 1'b0;
   bit            e_g0, e_g1, e_rv;
   logic [VW-1:0] exp_vec;

   function automatic logic [VW-1:0] dut_vec();
      return {req0_ready, req1_ready, res_valid, busy,
              res_valid ? res_id : 1'b0, res_valid ? res_q : {DW{1'b0}}, div_num, div_den};
   endfunction

   task automatic model_eval();
      bit            allow;
      logic [DW-1:0] nv, dv;
      allow = !rst && (mq.size() < FDEPTH);
      e_g0  = allow && req0_valid && (!req1_valid || !m_rr);
      e_g1  = allow && req1_valid && (!req0_valid || m_rr);
      nv    = e_g0 ? req0_num : (e_g1 ? req1_num : {DW{1'b0}});
      dv    = e_g0 ? req0_den : (e_g1 ? req1_den : {DW{1'b0}});
      e_rv  = (mq.size() > 0) && (mq[0].due <= cyc);
      exp_vec = {e_g0, e_g1, e_rv, mq.size() > 0,
                 e_rv ? mq[0].id : 1'b0, e_rv ? mq[0].q : {DW{1'b0}}, nv, dv};
   endtask

   task automatic model_commit();
      rec_t r;
      if (rst) begin
         mq.delete();
         m_rr = 1'b0;
      end else begin
         if (e_rv && res_ready) void'(mq.pop_front());
         if (e_g0 || e_g1) begin
            r.id  = e_g1;
            r.q   = e_g0 ? ((req0_den == '0) ? {DW{1'b1}} : req0_num / req0_den)
                         : ((req1_den == '0) ? {DW{1'b1}} : req1_num / req1_den);
            r.due = cyc + LAT + 1;
            mq.push_back(r);
            m_rr = e_g0;
         end
      end
      cyc++;
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic set_in(input bit v0, input bit v1, input bit rdy);
      req0_valid = v0;
      req1_valid = v1;
      res_ready  = rdy;
      req0_num   = DW'($urandom);
      req0_den   = DW'($urandom_range(1, 300));
      req1_num   = DW'($urandom);
      req1_den   = DW'($urandom_range(1, 300));
   endtask

   task automatic do_reset();
      set_in(0, 0, 0);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1 model_eval();
         advance();
      end
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 1);
         #1 model_eval();
         if (dut_vec() !== exp_vec) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
         else passed++;
         total++;
         advance();
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_in(0, 0, 0);
         #1 model_eval();
         if (dut_vec() !== exp_vec) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
         else passed++;
         total++;
         advance();
      end
   endtask

   task automatic test_single();
      int rise = -1;
      do_reset();
      set_in(1, 0, 1);
      req0_num = 16'd100;
      req0_den = 16'd7;
      for (int i = 0; i < 25; i++) begin
         #1 model_eval();
         if (dut_vec() !== exp_vec) $display("FAIL single cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
         else passed++;
         total++;
         if (res_valid && rise < 0) begin
            rise = i;
            if (res_q !== 16'd14 || res_id !== 1'b0) $display("FAIL single_q got=%0d/%0d exp=14/0", res_q, res_id);
            else passed++;
            total++;
         end
         advance();
         set_in(0, 0, 1);
      end
      if (rise !== LAT + 1) $display("FAIL single_latency got=%0d exp=%0d", rise, LAT + 1);
      else passed++;
      total++;
   endtask

   task automatic test_contention();
      logic [3:0] ids = '0;
      int         n = 0;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         set_in(i < 40, i < 40, 1);
         #1 model_eval();
         if (dut_vec() !== exp_vec) $display("FAIL contention cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
         else passed++;
         total++;
         if ((req0_ready || req1_ready) && n < 4) begin
            ids[n] = req1_ready;
            n++;
         end
         advance();
      end
      if (ids !== 4'b1010) $display("FAIL contention_order got=%b exp=1010", ids);
      else passed++;
      total++;
   endtask

   task automatic test_credit_stall();
      int acc = 0;
      do_reset();
      for (int i = 0; i < 70; i++) begin
         set_in(i < 50, 0, i >= 30);
         #1 model_eval();
         if (dut_vec() !== exp_vec) $display("FAIL credit cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
         else passed++;
         total++;
         if (i < 30 && req0_ready) acc++;
         advance();
      end
      if (acc !== FDEPTH) $display("FAIL credit_accepts got=%0d exp=%0d", acc, FDEPTH);
      else passed++;
      total++;
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      do_reset();
      for (int i = 0; i < 36; i++) begin
         set_in(i < 3, 0, 1);
         rst = (i == 5);
         #1 model_eval();
         if (dut_vec() !== exp_vec) $display("FAIL midreset cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
         else passed++;
         total++;
         if (i > 5 && res_valid) seen++;
         advance();
      end
      rst = 1'b0;
      if (seen !== 0) $display("FAIL midreset_results got=%0d exp=0", seen);
      else passed++;
      total++;
      set_in(1, 1, 1);
      #1 model_eval();
      if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL midreset_rr got=%b exp=10", {req0_ready, req1_ready});
      else passed++;
      total++;
      advance();
   endtask

   task automatic test_sparse();
      do_reset();
      for (int i = 0; i < 50; i++) begin
         set_in(0, (i % 3 == 0) && i < 30, $urandom_range(0, 1) == 1 || i >= 30);
         #1 model_eval();
         if (dut_vec() !== exp_vec) $display("FAIL sparse cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
         else passed++;
         total++;
         advance();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         set_in(i < 360 && $urandom_range(0, 2) != 0, i < 360 && $urandom_range(0, 2) != 0,
                i >= 360 || $urandom_range(0, 3) != 0);
         #1 model_eval();
         if (dut_vec() !== exp_vec) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec);
         else passed++;
         total++;
         advance();
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_contention();
      test_credit_stall();
      test_reset_midflight();
      test_sparse();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
